// File: rtl/st_stub_pair_sequencer.sv
// Stub pair sequencer: pops one stub-count word per crossing, then walks every
// inner-layer stub against the outer-layer stubs three at a time. Output strobes
// are delayed by MEM_LAT so they line up with the data returned by the stub memories.
module st_stub_pair_sequencer #(
  parameter int unsigned STUB_ADR_BITS = 6,
  parameter int unsigned CNT_BITS      = STUB_ADR_BITS + 1,
  parameter int unsigned MEM_LAT       = 2
) (
  input  logic                      proc_clk,
  input  logic                      reset_n,
  input  logic [2*CNT_BITS-1:0]     struct_stub_cnt,
  input  logic                      stub_cnt_fifo_empty,
  output logic                      stub_cnt_fifo_rd_en,
  output logic [STUB_ADR_BITS-1:0]  in_stub_adr,
  output logic [STUB_ADR_BITS-1:0]  out_stub_adr,
  output logic                      pair_valid,
  output logic [2:0]                pair_mask,
  output logic                      pair_first,
  output logic                      pair_last,
  output logic                      crossing_done,
  output logic                      busy,
  output logic                      cnt_ovf,
  output logic [15:0]               crossing_cnt
);

  // Comparisons against the counts need one extra bit so j+3 cannot wrap.
  localparam int unsigned XW = CNT_BITS + 1;
  localparam logic [CNT_BITS-1:0] MaxCnt = CNT_BITS'(2 ** STUB_ADR_BITS);

  typedef enum logic [2:0] {StIdle, StPop, StLoad, StRun, StDone} state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] mask;
    logic       first;
    logic       last;
    logic       done;
  } token_t;

  state_e                     state_q, state_d;
  logic [CNT_BITS-1:0]        in_cnt_q, in_cnt_d;
  logic [CNT_BITS-1:0]        out_cnt_q, out_cnt_d;
  logic [CNT_BITS-1:0]        i_q, i_d;
  logic [CNT_BITS-1:0]        j_q, j_d;
  logic                       ovf_q, ovf_d;
  logic [15:0]                xcnt_q, xcnt_d;
  logic                       busy_q;
  logic [STUB_ADR_BITS-1:0]   in_adr_q, out_adr_q;
  token_t                     tok;
  token_t                     dly_q [MEM_LAT];

  logic [CNT_BITS-1:0] in_raw, out_raw, in_clamp, out_clamp;
  logic [XW-1:0]       j_x, out_x;
  logic                row_end;

  assign in_raw    = struct_stub_cnt[CNT_BITS-1:0];
  assign out_raw   = struct_stub_cnt[2*CNT_BITS-1:CNT_BITS];
  assign in_clamp  = (in_raw > MaxCnt) ? MaxCnt : in_raw;
  assign out_clamp = (out_raw > MaxCnt) ? MaxCnt : out_raw;
  assign j_x       = {1'b0, j_q};
  assign out_x     = {1'b0, out_cnt_q};
  assign row_end   = (j_x + XW'(3)) >= out_x;

  // Next-state, counters and the token entering the delay line.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    i_d       = i_q;
    j_d       = j_q;
    ovf_d     = ovf_q;
    xcnt_d    = xcnt_q;
    tok       = '0;
    unique case (state_q)
      StIdle: begin
        if (!stub_cnt_fifo_empty) state_d = StPop;
      end
      StPop: begin
        state_d = StLoad;
      end
      StLoad: begin
        in_cnt_d  = in_clamp;
        out_cnt_d = out_clamp;
        if ((in_raw > MaxCnt) || (out_raw > MaxCnt)) ovf_d = 1'b1;
        i_d = '0;
        j_d = '0;
        if ((in_clamp == '0) || (out_clamp == '0)) state_d = StDone;
        else                                       state_d = StRun;
      end
      StRun: begin
        tok.valid = 1'b1;
        tok.mask  = {(j_x + XW'(2)) < out_x, (j_x + XW'(1)) < out_x, j_x < out_x};
        tok.first = (i_q == '0) && (j_q == '0);
        tok.last  = row_end && (i_q == in_cnt_q - CNT_BITS'(1));
        if (row_end) begin
          j_d = '0;
          i_d = i_q + CNT_BITS'(1);
        end else begin
          j_d = j_q + CNT_BITS'(3);
        end
        if (tok.last) state_d = StDone;
      end
      StDone: begin
        tok.done = 1'b1;
        xcnt_d   = xcnt_q + 16'd1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counts and status registers.
  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
      ovf_q     <= 1'b0;
      xcnt_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      i_q       <= i_d;
      j_q       <= j_d;
      ovf_q     <= ovf_d;
      xcnt_q    <= xcnt_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  // Remember the last issued addresses so they hold steady outside RUN.
  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_adr_q  <= '0;
      out_adr_q <= '0;
    end else if (state_q == StRun) begin
      in_adr_q  <= i_q[STUB_ADR_BITS-1:0];
      out_adr_q <= j_q[STUB_ADR_BITS-1:0];
    end
  end

  // Delay line aligning the strobes with the memory read data.
  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MEM_LAT; k++) dly_q[k] <= '0;
    end else begin
      dly_q[0] <= tok;
      for (int k = 1; k < MEM_LAT; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  assign stub_cnt_fifo_rd_en = (state_q == StPop);
  assign in_stub_adr   = (state_q == StRun) ? i_q[STUB_ADR_BITS-1:0] : in_adr_q;
  assign out_stub_adr  = (state_q == StRun) ? j_q[STUB_ADR_BITS-1:0] : out_adr_q;
  assign pair_valid    = dly_q[MEM_LAT-1].valid;
  assign pair_mask     = dly_q[MEM_LAT-1].mask;
  assign pair_first    = dly_q[MEM_LAT-1].first;
  assign pair_last     = dly_q[MEM_LAT-1].last;
  assign crossing_done = dly_q[MEM_LAT-1].done;
  assign busy          = busy_q;
  assign cnt_ovf       = ovf_q;
  assign crossing_cnt  = xcnt_q;

endmodule

// File: tb/tb_st_stub_pair_sequencer.sv
// Bench for st_stub_pair_sequencer: FIFO model feeds count words, a reference
// model pushes the expected token stream, a monitor pops and compares it.
module tb_st_stub_pair_sequencer;

  localparam int AB  = 6;
  localparam int CB  = AB + 1;
  localparam int LAT = 2;

  logic            proc_clk, reset_n;
  logic [2*CB-1:0] struct_stub_cnt;
  logic            stub_cnt_fifo_empty, stub_cnt_fifo_rd_en;
  logic [AB-1:0]   in_stub_adr, out_stub_adr;
  logic            pair_valid, pair_first, pair_last, crossing_done, busy, cnt_ovf;
  logic [2:0]      pair_mask;
  logic [15:0]     crossing_cnt;

  st_stub_pair_sequencer #(.STUB_ADR_BITS(AB), .CNT_BITS(CB), .MEM_LAT(LAT)) dut (
    .proc_clk            (proc_clk),
    .reset_n             (reset_n),
    .struct_stub_cnt     (struct_stub_cnt),
    .stub_cnt_fifo_empty (stub_cnt_fifo_empty),
    .stub_cnt_fifo_rd_en (stub_cnt_fifo_rd_en),
    .in_stub_adr         (in_stub_adr),
    .out_stub_adr        (out_stub_adr),
    .pair_valid          (pair_valid),
    .pair_mask           (pair_mask),
    .pair_first          (pair_first),
    .pair_last           (pair_last),
    .crossing_done       (crossing_done),
    .busy                (busy),
    .cnt_ovf             (cnt_ovf),
    .crossing_cnt        (crossing_cnt)
  );

  typedef struct packed {
    logic          done;
    logic          valid;
    logic [2:0]    mask;
    logic          first;
    logic          last;
    logic [AB-1:0] in_adr;
    logic [AB-1:0] out_adr;
  } tok_t;

  typedef struct {
    int in_c;
    int out_c;
    int exp_pairs;
    bit exp_ovf;
  } vec_t;

  tok_t            sb[$];
  logic [2*CB-1:0] fifo_q[$];
  int              rd_cyc[$];
  int total = 0, bad = 0;
  int cyc = 0, pairs_seen = 0, dones_seen = 0, rd_cnt = 0;
  int exp_cross = 0, exp_rd = 0;
  logic [AB-1:0] hist_in [LAT];
  logic [AB-1:0] hist_out[LAT];

  initial begin
    proc_clk = 1'b0;
    forever #5 proc_clk = ~proc_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: push a count word and the expected token stream for it.
  task automatic push_word(input int in_c, input int out_c);
    int   ic, oc;
    tok_t t;
    ic = (in_c > 64) ? 64 : in_c;
    oc = (out_c > 64) ? 64 : out_c;
    for (int i = 0; i < ic; i++) begin
      for (int j = 0; j < oc; j += 3) begin
        t.done    = 1'b0;
        t.valid   = 1'b1;
        t.mask    = {(j + 2 < oc), (j + 1 < oc), 1'b1};
        t.first   = (i == 0) && (j == 0);
        t.last    = (i == ic - 1) && (j + 3 >= oc);
        t.in_adr  = AB'(i);
        t.out_adr = AB'(j);
        sb.push_back(t);
      end
    end
    t = '0;
    t.done = 1'b1;
    sb.push_back(t);
    fifo_q.push_back({CB'(out_c), CB'(in_c)});
    stub_cnt_fifo_empty = 1'b0;
    exp_rd++;
  endtask

  task automatic wait_dones(input int target);
    bit ok = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge proc_clk);
      if (dones_seen >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_word(input vec_t v);
    int p0, target;
    p0 = pairs_seen;
    target = dones_seen + 1;
    @(negedge proc_clk); #1;
    push_word(v.in_c, v.out_c);
    exp_cross++;
    wait_dones(target);
    repeat (2) @(negedge proc_clk);
    check($sformatf("pairs_%0d_%0d", v.in_c, v.out_c), 64'(pairs_seen - p0), 64'(v.exp_pairs));
    check("cnt_ovf", 64'(cnt_ovf), 64'(v.exp_ovf));
    check("crossing_cnt", 64'(crossing_cnt), 64'(exp_cross));
    check("busy_idle", 64'(busy), 64'd0);
    check("rd_en_count", 64'(rd_cnt), 64'(exp_rd));
  endtask

  // FIFO model: data valid the cycle after the pop strobe.
  initial begin
    forever begin
      @(negedge proc_clk);
      if (reset_n && stub_cnt_fifo_rd_en) begin
        if (fifo_q.size() == 0) check("rd_en_on_empty", 64'd1, 64'd0);
        else struct_stub_cnt = fifo_q.pop_front();
      end
      stub_cnt_fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: compare every emitted token against the scoreboard.
  initial begin
    tok_t act;
    forever begin
      @(negedge proc_clk);
      cyc++;
      if (!reset_n) begin
        for (int k = 0; k < LAT; k++) begin
          hist_in[k]  = '0;
          hist_out[k] = '0;
        end
      end else begin
        if (stub_cnt_fifo_rd_en) begin
          rd_cnt++;
          rd_cyc.push_back(cyc);
        end
        if (pair_valid || crossing_done) begin
          act = {crossing_done, pair_valid, pair_mask, pair_first, pair_last,
                 hist_in[LAT-1], hist_out[LAT-1]};
          if (!pair_valid) begin
            act.in_adr  = '0;
            act.out_adr = '0;
          end
          if (pair_valid) pairs_seen++;
          if (crossing_done) dones_seen++;
          if (sb.size() == 0) check("unexpected_token", 64'(act), 64'd0);
          else check("token", 64'(act), 64'(sb.pop_front()));
        end
        for (int k = LAT - 1; k > 0; k--) begin
          hist_in[k]  = hist_in[k-1];
          hist_out[k] = hist_out[k-1];
        end
        hist_in[0]  = in_stub_adr;
        hist_out[0] = out_stub_adr;
      end
    end
  end

  initial begin
    vec_t vecs[10];
    int   t0, d0;
    bit   ok;
    vecs[0] = '{2, 4, 4, 0};
    vecs[1] = '{1, 3, 1, 0};
    vecs[2] = '{0, 5, 0, 0};
    vecs[3] = '{5, 0, 0, 0};
    vecs[4] = '{3, 7, 9, 0};
    vecs[5] = '{1, 64, 22, 0};
    vecs[6] = '{64, 1, 64, 0};
    vecs[7] = '{65, 1, 64, 1};
    vecs[8] = '{2, 100, 44, 1};
    vecs[9] = '{127, 127, 1408, 1};

    reset_n = 1'b0;
    struct_stub_cnt = '0;
    stub_cnt_fifo_empty = 1'b1;
    repeat (3) @(negedge proc_clk);
    check("reset_outputs", 64'({stub_cnt_fifo_rd_en, in_stub_adr, out_stub_adr, pair_valid,
          pair_mask, pair_first, pair_last, crossing_done, busy, cnt_ovf, crossing_cnt}), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge proc_clk);
    check("idle_no_pop", 64'(rd_cnt), 64'd0);

    foreach (vecs[k]) run_word(vecs[k]);

    // Back-to-back crossings with the FIFO held non-empty.
    t0 = rd_cyc.size();
    d0 = dones_seen;
    @(negedge proc_clk); #1;
    push_word(1, 1);
    push_word(2, 2);
    exp_cross += 2;
    wait_dones(d0 + 2);
    repeat (2) @(negedge proc_clk);
    check("b2b_rd_count", 64'(rd_cyc.size() - t0), 64'd2);
    if (rd_cyc.size() - t0 == 2)
      check("b2b_rd_spacing", 64'(rd_cyc[t0+1] - rd_cyc[t0]), 64'd5);
    check("b2b_crossing_cnt", 64'(crossing_cnt), 64'(exp_cross));
    t0 = rd_cyc.size();
    d0 = dones_seen;
    @(negedge proc_clk); #1;
    push_word(2, 2);
    push_word(1, 3);
    exp_cross += 2;
    wait_dones(d0 + 2);
    repeat (2) @(negedge proc_clk);
    if (rd_cyc.size() - t0 == 2)
      check("b2b_rd_spacing6", 64'(rd_cyc[t0+1] - rd_cyc[t0]), 64'd6);
    else check("b2b_rd_count2", 64'(rd_cyc.size() - t0), 64'd2);

    // Reset in the middle of a crossing, during i=1.
    @(negedge proc_clk); #1;
    push_word(4, 9);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge proc_clk);
      if (pair_valid) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      ok = 0;
      for (int n = 0; n < 200; n++) begin
        if (busy && in_stub_adr == AB'(1)) begin
          ok = 1;
          break;
        end
        @(negedge proc_clk);
      end
    end
    check("reach_i1", 64'(ok), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({stub_cnt_fifo_rd_en, in_stub_adr, out_stub_adr,
          pair_valid, pair_mask, pair_first, pair_last, crossing_done, busy, cnt_ovf,
          crossing_cnt}), 64'd0);
    sb.delete();
    exp_cross = 0;
    d0 = dones_seen;
    repeat (3) @(negedge proc_clk);
    reset_n = 1'b1;
    repeat (12) @(negedge proc_clk);
    check("no_done_after_reset", 64'(dones_seen - d0), 64'd0);
    run_word('{3, 4, 6, 0});
    run_word('{1, 2, 1, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/st_stub_pair_sequencer.md
# st_stub_pair_sequencer

Sequencer for the stub tagging datapath: pops one per-crossing stub-count word from the stub count FIFO, then walks every inner-layer stub against the outer-layer stubs three at a time (ports a/b/c). It drives `in_stub_adr`/`out_stub_adr` into the stub memories and emits valid, mask and framing strobes aligned with the returned stub data. It sits between the stub processing block and the tracklet search engine, in the `proc_clk` domain.

## Interface
- `STUB_ADR_BITS`, 6: stub memory address width.
- `CNT_BITS`, `STUB_ADR_BITS+1`: width of each stub count field.
- `MEM_LAT`, 2: stub memory read latency in cycles (≥1); depth of the output alignment delay line.
- `proc_clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `struct_stub_cnt` in 2*CNT_BITS: {out_cnt, in_cnt}; valid the cycle after `stub_cnt_fifo_rd_en`.
- `stub_cnt_fifo_empty` in 1: count FIFO empty.
- `stub_cnt_fifo_rd_en` out 1: single-cycle pop strobe.
- `in_stub_adr` out STUB_ADR_BITS: inner stub address.
- `out_stub_adr` out STUB_ADR_BITS: outer group base address; memory returns stubs j, j+1, j+2 on a/b/c.
- `pair_valid` out 1: stub data on a/b/c and the inner port is a valid combination (delayed by MEM_LAT).
- `pair_mask` out 3: {c,b,a} per-port valid (delayed by MEM_LAT).
- `pair_first` out 1: first pair of a crossing (delayed by MEM_LAT).
- `pair_last` out 1: last pair of a crossing (delayed by MEM_LAT).
- `crossing_done` out 1: one-cycle pulse per popped crossing, including empty crossings.
- `busy` out 1: state ≠ IDLE.
- `cnt_ovf` out 1: sticky; a count exceeded 2^STUB_ADR_BITS.
- `crossing_cnt` out 16: crossings completed; wraps at 0xFFFF→0.

## Operation
- States: IDLE, POP, LOAD, RUN, DONE.
- IDLE: if `stub_cnt_fifo_empty`=0 → POP.
- POP: `stub_cnt_fifo_rd_en`=1 for exactly this cycle → LOAD.
- LOAD: capture counts. Any count > 2^STUB_ADR_BITS clamps to 2^STUB_ADR_BITS and sets `cnt_ovf`. Clear i and j.
  - If either clamped count = 0 → DONE.
  - Otherwise → RUN.
- RUN: each cycle drive `in_stub_adr`=i, `out_stub_adr`=j, and issue a token.
  - Token mask: a=(j<out_cnt), b=(j+1<out_cnt), c=(j+2<out_cnt).
  - first = (i=0 && j=0).
  - last = (i=in_cnt-1 && j+3≥out_cnt).
  - Step: if j+3≥out_cnt then j←0, i←i+1; else j←j+3. Compare at CNT_BITS+1 width.
  - After the last token → DONE.
- DONE: issue a done token, increment `crossing_cnt` → IDLE.
- Delay line: MEM_LAT stages carry {valid, mask, first, last, done}. Outputs are driven from the final stage.
- No backpressure. Downstream accepts one pair per cycle.
- Addresses are held at their last value outside RUN. In IDLE/POP/LOAD/DONE, tokens carry valid=0 and mask=0.

## Timing
- Reset: all outputs, state, counters, `cnt_ovf` and delay line clear to 0 asynchronously; state returns to IDLE. A popped but unfinished crossing is discarded; no `crossing_done` is emitted for it.
- Pop latency: empty low in cycle n (IDLE) → `rd_en` high in n+1 → counts captured at end of n+2 → first address in n+3.
- `pair_valid` for the address issued in cycle k appears in cycle k+MEM_LAT.
- `crossing_done` appears one cycle after the last `pair_valid`. For an empty crossing it appears MEM_LAT cycles after DONE.
- Cycles per crossing: in_cnt·ceil(out_cnt/3) + 4. IDLE is re-entered after DONE, so back-to-back pops are spaced by at least that many cycles.
- `busy` is registered with the state.

## Test plan
- Addressing order: in_cnt=2, out_cnt=4, MEM_LAT=2.
  - Required addresses (i,j): (0,0),(0,3),(1,0),(1,3).
  - Required masks: 111, 001, 111, 001.
  - `pair_first` on pair 1, `pair_last` on pair 4; `crossing_done` one cycle after pair 4; `crossing_cnt`=1.
- Exact multiple of three: in_cnt=1, out_cnt=3 → exactly one pair with mask 111, first=last=1.
- Empty crossings: {0,5} and then {5,0} → no `pair_valid`; two `crossing_done` pulses; `crossing_cnt`=2; one `rd_en` per crossing.
- Back-to-back crossings: FIFO holds {1,1},{2,2} with empty held low.
  - `rd_en` pulses are 5 and 6 cycles apart.
  - The first pair of crossing 2 has mask 011.
- Clamping: in_cnt=65, out_cnt=1 with STUB_ADR_BITS=6 → `cnt_ovf`=1; 64 pairs with i=0..63, each mask 001.
- Reset mid-run: in_cnt=4, out_cnt=9, assert `reset_n` low during i=1.
  - All outputs return to 0 immediately, no `crossing_done`.
  - After release, the next FIFO word is processed normally.
